// File: rtl/px_stream_fetcher.sv
// Frame reader: walks a CFG_ROWS x CFG_WIDTH pixel window in row-bounded bursts and
// streams the pixels out through a small FIFO tagged with row/frame boundaries.
module px_stream_fetcher #(
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_MAX  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] cfg_base_addr,
    input  logic [8:0]  cfg_width,
    input  logic [8:0]  cfg_rows,
    output logic        busy,
    output logic        done,
    output logic        pxMem_RD_REQ,
    output logic [19:0] pxMem_RD_Addr,
    output logic [3:0]  pxMem_RD_burst,
    input  logic        pxMem_RD_GRANT,
    input  logic        pxMem_RD_VLD,
    output logic        pxMem_RD_RDY,
    input  logic [15:0] pxMem_in,
    output logic        track_read,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_row_last,
    output logic        out_frame_last
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 18;

    typedef enum logic [2:0] {IDLE, REQ, DATA, NEXT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [19:0] addr_reg, addr_next;
    logic [8:0]  width_reg, width_next;
    logic [8:0]  rows_reg, rows_next;
    logic [8:0]  col_reg, col_next;
    logic [8:0]  row_reg, row_next;
    logic [4:0]  beat_reg, beat_next;
    logic        done_reg, done_next;

    logic [8:0]  remaining;
    logic [4:0]  len;
    logic [4:0]  len_m1;
    logic [9:0]  col_end;
    logic        row_end;
    logic        last_row;
    logic        beat_fire;
    logic        final_beat;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg;
    logic [ENTRY_W-1:0] head_reg;
    logic [ENTRY_W-1:0] push_entry;
    logic               push, pop;

    // Burst length is clipped to the rest of the current row so no burst spans rows.
    always_comb begin
        remaining = width_reg - col_reg;
        len       = (remaining > 9'(BURST_MAX)) ? 5'(BURST_MAX) : remaining[4:0];
        len_m1    = len - 5'd1;
        col_end   = {1'b0, col_reg} + {5'd0, len};
        row_end   = (col_end == {1'b0, width_reg});
        last_row  = (row_reg == rows_reg - 9'd1);
    end

    assign beat_fire  = pxMem_RD_VLD & pxMem_RD_RDY;
    assign final_beat = beat_fire & (beat_reg == len_m1);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        width_next = width_reg;
        rows_next  = rows_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        beat_next  = beat_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    width_next = cfg_width;
                    rows_next  = cfg_rows;
                    addr_next  = cfg_base_addr;
                    col_next   = 9'd0;
                    row_next   = 9'd0;
                    state_next = (cfg_width == 9'd0 || cfg_rows == 9'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (pxMem_RD_GRANT) begin
                    beat_next  = 5'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (beat_fire) begin
                    beat_next = beat_reg + 5'd1;
                    if (final_beat) begin
                        state_next = NEXT;
                    end
                end
            end
            NEXT: begin
                addr_next = addr_reg + 20'(len);
                if (row_end) begin
                    col_next   = 9'd0;
                    row_next   = row_reg + 9'd1;
                    state_next = last_row ? DONE : REQ;
                end else begin
                    col_next   = col_end[8:0];
                    state_next = REQ;
                end
            end
            DONE: begin
                if (count_reg == '0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            width_reg <= '0;
            rows_reg  <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
            beat_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            width_reg <= width_next;
            rows_reg  <= rows_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            beat_reg  <= beat_next;
            done_reg  <= done_next;
        end
    end

    assign busy           = (state_reg != IDLE);
    assign done           = done_reg;
    assign pxMem_RD_REQ   = (state_reg == REQ);
    assign pxMem_RD_Addr  = (state_reg == REQ) ? addr_reg : 20'd0;
    assign pxMem_RD_burst = (state_reg == REQ) ? len_m1[3:0] : 4'd0;
    assign pxMem_RD_RDY   = (state_reg == DATA) && (count_reg < CNT_W'(FIFO_DEPTH));
    assign track_read     = (state_reg == NEXT);

    // Output FIFO: tags ride along with each pixel so boundaries survive back-pressure.
    assign push        = beat_fire;
    assign pop         = out_valid & out_ready;
    assign push_entry  = {final_beat & row_end, final_beat & row_end & last_row, pxMem_in};
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
        // Write-first bypass when the incoming beat becomes the new head.
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= push_entry;
        end else begin
            head_reg <= fifo_mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_valid      = (count_reg != '0);
    assign out_data       = out_valid ? head_reg[15:0] : 16'd0;
    assign out_frame_last = out_valid & head_reg[16];
    assign out_row_last   = out_valid & head_reg[17];

endmodule

// File: tb/tb_px_stream_fetcher.sv
// Randomized bench for px_stream_fetcher: a pxMem responder and a consumer run alongside
// scenario tasks that compare observed requests, pixels and pulses with a frame-level model.
module tb_px_stream_fetcher;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [19:0] cfg_base_addr = '0;
    logic [8:0]  cfg_width = '0;
    logic [8:0]  cfg_rows = '0;
    logic        busy, done, pxMem_RD_REQ, pxMem_RD_RDY, track_read;
    logic [19:0] pxMem_RD_Addr;
    logic [3:0]  pxMem_RD_burst;
    logic        pxMem_RD_GRANT, pxMem_RD_VLD, out_ready;
    logic [15:0] pxMem_in, out_data;
    logic        out_valid, out_row_last, out_frame_last;

    always #5 clk = ~clk;

    px_stream_fetcher dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_width(cfg_width), .cfg_rows(cfg_rows),
        .busy(busy), .done(done),
        .pxMem_RD_REQ(pxMem_RD_REQ), .pxMem_RD_Addr(pxMem_RD_Addr), .pxMem_RD_burst(pxMem_RD_burst),
        .pxMem_RD_GRANT(pxMem_RD_GRANT), .pxMem_RD_VLD(pxMem_RD_VLD), .pxMem_RD_RDY(pxMem_RD_RDY),
        .pxMem_in(pxMem_in), .track_read(track_read),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row_last(out_row_last), .out_frame_last(out_frame_last)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit timed_out;

    int grant_delay = 1;
    int vld_pct = 100;
    int ready_pct = 100;
    logic [15:0] data_seed = 16'h1234;

    logic [19:0] burst_addr, first_addr, g_addr;
    logic [3:0]  first_burst;
    int          remaining, req_wait, g_len;
    bit          p_grant, p_beat, p_pop;
    logic [17:0] p_px;

    logic [23:0] req_log[$];
    int          req_cyc[$];
    int          req_hold[$];
    int          final_cyc[$];
    int          track_cyc[$];
    bit          rdy_ag[$];
    logic [17:0] obs_px[$];
    int          beats_total, done_cnt, done_cyc, done_obs_n, req_unstable, overlap_err;
    logic        done_busy;

    logic [23:0] exp_req[$];
    logic [17:0] exp_px[$];

    function automatic logic [15:0] px_of(input logic [19:0] a);
        logic [35:0] p;
        p = {16'd0, a} * 36'd40503;
        return p[15:0] ^ data_seed ^ {a[19:16], 12'h000};
    endfunction

    // Environment: pxMem responder, consumer and monitor in one process to keep ordering fixed.
    initial begin
        pxMem_RD_GRANT = 1'b0; pxMem_RD_VLD = 1'b0; pxMem_in = '0; out_ready = 1'b0;
        remaining = 0; req_wait = 0; p_grant = 0; p_beat = 0; p_pop = 0;
        burst_addr = '0; first_addr = '0; first_burst = '0; g_addr = '0; g_len = 0; p_px = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                remaining = 0; req_wait = 0; p_grant = 0; p_beat = 0; p_pop = 0;
                pxMem_RD_GRANT = 1'b0; pxMem_RD_VLD = 1'b0; pxMem_in = '0; out_ready = 1'b0;
            end else begin
                if (p_grant) begin
                    burst_addr = g_addr; remaining = g_len; req_wait = 0;
                    rdy_ag.push_back(pxMem_RD_RDY);
                end
                if (p_beat) begin
                    beats_total++; burst_addr = burst_addr + 20'd1; remaining--;
                    pxMem_RD_VLD = 1'b0;
                    if (remaining == 0) final_cyc.push_back(cyc - 1);
                end
                if (p_pop) obs_px.push_back(p_px);
                if (track_read) track_cyc.push_back(cyc);
                if (done) begin
                    done_cnt++; done_cyc = cyc; done_busy = busy; done_obs_n = obs_px.size();
                end
                if (pxMem_RD_REQ && pxMem_RD_RDY) overlap_err++;
                pxMem_RD_GRANT = 1'b0;
                if (pxMem_RD_REQ && remaining == 0) begin
                    if (req_wait == 0) begin
                        req_log.push_back({pxMem_RD_burst, pxMem_RD_Addr});
                        req_cyc.push_back(cyc);
                        first_addr = pxMem_RD_Addr; first_burst = pxMem_RD_burst;
                    end else if (pxMem_RD_Addr != first_addr || pxMem_RD_burst != first_burst) begin
                        req_unstable++;
                    end
                    req_wait++;
                    if (req_wait >= grant_delay) begin
                        pxMem_RD_GRANT = 1'b1;
                        req_hold.push_back(req_wait);
                    end
                end
                p_grant = pxMem_RD_GRANT;
                g_addr  = pxMem_RD_Addr;
                g_len   = int'(pxMem_RD_burst) + 1;
                if (remaining > 0 && !pxMem_RD_VLD)
                    pxMem_RD_VLD = (int'($urandom_range(0, 99)) < vld_pct);
                pxMem_in  = pxMem_RD_VLD ? px_of(burst_addr) : 16'h0;
                p_beat    = pxMem_RD_VLD && pxMem_RD_RDY;
                out_ready = (int'($urandom_range(0, 99)) < ready_pct);
                p_pop     = out_valid && out_ready;
                p_px      = {out_row_last, out_frame_last, out_data};
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        req_log.delete(); req_cyc.delete(); req_hold.delete(); final_cyc.delete();
        track_cyc.delete(); rdy_ag.delete(); obs_px.delete();
        beats_total = 0; done_cnt = 0; done_cyc = 0; done_obs_n = 0;
        req_unstable = 0; overlap_err = 0; done_busy = 1'b0;
    endtask

    // Frame-level reference: request list and pixel stream from base/width/rows alone.
    task automatic build_expect(input logic [19:0] base, input int w, input int rows);
        int col, len;
        exp_req.delete(); exp_px.delete();
        for (int r = 0; r < rows; r++) begin
            col = 0;
            while (col < w) begin
                len = (w - col > 16) ? 16 : (w - col);
                exp_req.push_back({4'(len - 1), 20'(int'(base) + r * w + col)});
                col += len;
            end
        end
        for (int i = 0; i < w * rows; i++)
            exp_px.push_back({((i % w) == w - 1), (i == w * rows - 1), px_of(20'(int'(base) + i))});
    endtask

    task automatic launch(input logic [19:0] base, input int w, input int rows);
        @(posedge clk); #2;
        cfg_base_addr = base; cfg_width = 9'(w); cfg_rows = 9'(rows);
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            @(posedge clk); #2;
            n++;
        end
        timed_out = (done_cnt == 0);
        repeat (4) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic test_reset();
        logic [47:0] outs;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
        end
        outs = {busy, done, pxMem_RD_REQ, pxMem_RD_Addr, pxMem_RD_burst, pxMem_RD_RDY,
                track_read, out_data, out_valid, out_row_last, out_frame_last};
        vectors++;
        if (outs !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_stream_frame(input logic [19:0] base, input int w, input int rows,
                                     input int gd, input int vp, input int rp, input bit poke);
        clear_logs();
        grant_delay = gd; vld_pct = vp; ready_pct = rp; data_seed = 16'($urandom);
        build_expect(base, w, rows);
        launch(base, w, rows);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        if (poke) begin
            repeat (3) begin
                @(posedge clk); #2;
            end
            if (done_cnt == 0) begin
                cfg_base_addr = 20'h0; cfg_width = 9'd7; cfg_rows = 9'd1; start = 1'b1;
                @(posedge clk); #2;
                start = 1'b0;
            end
        end
        wait_done(6000);
        vectors++;
        if (timed_out) begin
            miscompares++;
            $display("FAIL done_timeout: got no done expected done within 6000 cycles (w=%0d rows=%0d)", w, rows);
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL done_pulse_cycles: got %0d expected 1", done_cnt);
        end
        vectors++;
        if (done_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_at_done: got %b expected 0", done_busy);
        end
        vectors++;
        if (done_obs_n != exp_px.size()) begin
            miscompares++;
            $display("FAIL pixels_before_done: got %0d expected %0d", done_obs_n, exp_px.size());
        end
        vectors++;
        if (req_log.size() != exp_req.size()) begin
            miscompares++;
            $display("FAIL req_count: got %0d expected %0d", req_log.size(), exp_req.size());
        end
        for (int i = 0; i < req_log.size() && i < exp_req.size(); i++) begin
            vectors++;
            if (req_log[i] !== exp_req[i]) begin
                miscompares++;
                $display("FAIL req[%0d] burst/addr: got %h expected %h", i, req_log[i], exp_req[i]);
            end
        end
        vectors++;
        if (req_unstable != 0 || overlap_err != 0) begin
            miscompares++;
            $display("FAIL req_protocol: got unstable=%0d req_rdy_overlap=%0d expected 0/0", req_unstable, overlap_err);
        end
        if (exp_req.size() > 0 && req_cyc.size() > 0) begin
            vectors++;
            if (req_cyc[0] - start_cyc != 1) begin
                miscompares++;
                $display("FAIL start_to_req: got %0d cycles expected 1", req_cyc[0] - start_cyc);
            end
        end
        foreach (req_hold[i]) begin
            vectors++;
            if (req_hold[i] != gd) begin
                miscompares++;
                $display("FAIL req_hold[%0d]: got %0d cycles expected %0d", i, req_hold[i], gd);
            end
        end
        vectors++;
        if (track_cyc.size() != exp_req.size()) begin
            miscompares++;
            $display("FAIL track_read_count: got %0d expected %0d", track_cyc.size(), exp_req.size());
        end
        for (int i = 0; i < final_cyc.size(); i++) begin
            if (i < track_cyc.size()) begin
                vectors++;
                if (track_cyc[i] != final_cyc[i] + 1) begin
                    miscompares++;
                    $display("FAIL track_read_timing[%0d]: got cycle %0d expected %0d", i, track_cyc[i], final_cyc[i] + 1);
                end
            end
            if (i + 1 < req_cyc.size()) begin
                vectors++;
                if (req_cyc[i + 1] != final_cyc[i] + 2) begin
                    miscompares++;
                    $display("FAIL burst_end_to_req[%0d]: got cycle %0d expected %0d", i, req_cyc[i + 1], final_cyc[i] + 2);
                end
            end
        end
        if (rp == 100) begin
            foreach (rdy_ag[i]) begin
                vectors++;
                if (rdy_ag[i] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL grant_to_rdy[%0d]: got %b expected 1", i, rdy_ag[i]);
                end
            end
        end
        vectors++;
        if (obs_px.size() != exp_px.size()) begin
            miscompares++;
            $display("FAIL pixel_count: got %0d expected %0d", obs_px.size(), exp_px.size());
        end
        for (int i = 0; i < obs_px.size() && i < exp_px.size(); i++) begin
            vectors++;
            if (obs_px[i] !== exp_px[i]) begin
                miscompares++;
                $display("FAIL pixel[%0d] {row_last,frame_last,data}: got %h expected %h", i, obs_px[i], exp_px[i]);
            end
        end
        $display("frame base=%05h w=%0d rows=%0d grant_delay=%0d: %0d reqs, %0d pixels", base, w, rows, gd, req_log.size(), obs_px.size());
    endtask

    task automatic test_multi_row();
        test_stream_frame(20'h00100, 28, 2, 1, 100, 100, 1'b0);
    endtask

    task automatic test_backpressure();
        clear_logs();
        grant_delay = 1; vld_pct = 100; ready_pct = 0; data_seed = 16'($urandom);
        build_expect(20'h03A40, 16, 1);
        launch(20'h03A40, 16, 1);
        repeat (40) begin
            @(posedge clk); #2;
        end
        vectors++;
        if (beats_total != 8) begin
            miscompares++;
            $display("FAIL full_fifo_beats: got %0d expected 8", beats_total);
        end
        vectors++;
        if (pxMem_RD_RDY !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_fifo_flags: got rdy=%b valid=%b expected rdy=0 valid=1", pxMem_RD_RDY, out_valid);
        end
        vectors++;
        if ({out_row_last, out_frame_last, out_data} !== exp_px[0] || obs_px.size() != 0) begin
            miscompares++;
            $display("FAIL stalled_head: got %h (popped %0d) expected %h (popped 0)",
                     {out_row_last, out_frame_last, out_data}, obs_px.size(), exp_px[0]);
        end
        ready_pct = 100;
        wait_done(2000);
        vectors++;
        if (timed_out || done_cnt != 1) begin
            miscompares++;
            $display("FAIL backpressure_done: got %0d done cycles expected 1", done_cnt);
        end
        vectors++;
        if (obs_px.size() != 16 || track_cyc.size() != 1) begin
            miscompares++;
            $display("FAIL backpressure_counts: got px=%0d track=%0d expected 16/1", obs_px.size(), track_cyc.size());
        end
        for (int i = 0; i < obs_px.size() && i < exp_px.size(); i++) begin
            vectors++;
            if (obs_px[i] !== exp_px[i]) begin
                miscompares++;
                $display("FAIL backpressure_pixel[%0d]: got %h expected %h", i, obs_px[i], exp_px[i]);
            end
        end
        $display("backpressure frame: %0d pixels after release", obs_px.size());
    endtask

    task automatic test_grant_delay();
        test_stream_frame(20'($urandom), 20, 1, 5, 100, 100, 1'b0);
    endtask

    task automatic test_empty_frame();
        test_stream_frame(20'h00400, 0, 3, 1, 100, 100, 1'b0);
        vectors++;
        if (done_cyc - start_cyc != 2) begin
            miscompares++;
            $display("FAIL empty_w_done_latency: got %0d expected 2", done_cyc - start_cyc);
        end
        test_stream_frame(20'h00400, 5, 0, 1, 100, 100, 1'b0);
        vectors++;
        if (done_cyc - start_cyc != 2) begin
            miscompares++;
            $display("FAIL empty_rows_done_latency: got %0d expected 2", done_cyc - start_cyc);
        end
    endtask

    task automatic test_addr_wrap();
        test_stream_frame(20'hFFFF8, 16, 1, 1, 100, 100, 1'b0);
        test_stream_frame(20'hFFFFC, 20, 2, 2, 70, 60, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        logic [47:0] outs;
        int n;
        clear_logs();
        grant_delay = 1; vld_pct = 100; ready_pct = 100; data_seed = 16'($urandom);
        launch(20'h12340, 40, 2);
        n = 0;
        while (beats_total < 4 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        vectors++;
        if (beats_total != 4) begin
            miscompares++;
            $display("FAIL mid_burst_setup: got %0d beats expected 4", beats_total);
        end
        rst = 1'b1;
        @(posedge clk); #2;
        outs = {busy, done, pxMem_RD_REQ, pxMem_RD_Addr, pxMem_RD_burst, pxMem_RD_RDY,
                track_read, out_data, out_valid, out_row_last, out_frame_last};
        vectors++;
        if (outs !== 48'd0) begin
            miscompares++;
            $display("FAIL mid_burst_reset_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #2;
        end
        vectors++;
        if (done_cnt != 0 || busy !== 1'b0 || pxMem_RD_REQ !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_quiet: got done=%0d busy=%b req=%b expected 0/0/0", done_cnt, busy, pxMem_RD_REQ);
        end
        test_stream_frame(20'h12340, 40, 2, 1, 100, 100, 1'b0);
    endtask

    task automatic test_start_ignored();
        test_stream_frame(20'h08000, 48, 2, 1, 80, 70, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++)
            test_stream_frame(20'($urandom), int'($urandom_range(1, 40)), int'($urandom_range(1, 4)),
                              int'($urandom_range(1, 3)), int'($urandom_range(40, 100)),
                              int'($urandom_range(20, 100)), 1'b0);
    endtask

    initial begin
        test_reset();
        test_multi_row();
        test_backpressure();
        test_grant_delay();
        test_empty_frame();
        test_addr_wrap();
        test_reset_mid_burst();
        test_start_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
